// File: rtl/j1a_bus_bridge.sv
// j1a_bus_bridge: bus slave for the J1A CPU's lock-step instruction/data buses.
// One CPU strobe starts a program-ROM fetch and, optionally, one Wishbone data
// access. A single acknowledge pulse is returned once both have completed.
// Optional feature: define J1A_BRIDGE_TIMEOUT_EN to abort Wishbone cycles that
// wait TIMEOUT_CYCLES without wb_ack_i. The abort returns 16'hFFFF on reads and
// raises the sticky bus_err_o flag.
module j1a_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        sys_clk_i,
  input  logic        sys_res_n_i,
  input  logic [12:0] cpu_ins_adr_i,
  input  logic        cpu_ins_cyc_i,
  input  logic [14:0] cpu_dat_adr_i,
  input  logic [15:0] cpu_dat_dat_i,
  input  logic        cpu_dat_we_i,
  input  logic        cpu_dat_cyc_i,
  input  logic        cpu_stb_i,
  output logic        cpu_ack_o,
  output logic [15:0] cpu_ins_dat_o,
  output logic [15:0] cpu_dat_dat_o,
  output logic [12:0] rom_adr_o,
  input  logic [15:0] rom_dat_i,
  output logic [14:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic [1:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {IDLE, RUN, ACK} state_t;

  state_t      state_reg, state_next;
  logic        ins_req_reg, dat_req_reg;
  logic        ins_done_reg, dat_done_reg;
  logic [12:0] rom_adr_reg;
  logic [14:0] wb_adr_reg;
  logic [15:0] wb_dat_reg;
  logic        wb_we_reg, wb_cyc_reg;
  logic [15:0] ins_dat_reg, dat_dat_reg;
  logic        start, wb_ack_seen, timeout_hit;
  logic        ins_done_next, dat_done_next;

  // A new transaction is accepted only from IDLE, which also guarantees the
  // dead cycle after every acknowledge.
  assign start       = (state_reg == IDLE) && cpu_stb_i;
  // Acks that arrive while no Wishbone cycle is open are ignored.
  assign wb_ack_seen = wb_cyc_reg & wb_ack_i;

  // The ROM presents its word in the first RUN cycle, so the fetch side is
  // always finished by the end of that cycle.
  assign ins_done_next = ins_done_reg | (state_reg == RUN);
  assign dat_done_next = dat_done_reg | wb_ack_seen | timeout_hit;

`ifdef J1A_BRIDGE_TIMEOUT_EN
  logic [7:0] tmo_cnt_reg;
  logic       bus_err_reg;

  // Timeout fires in the cycle the wait count reaches TIMEOUT_CYCLES; a
  // coincident ack takes priority.
  assign timeout_hit = wb_cyc_reg & ~wb_ack_i &
                       (tmo_cnt_reg == 8'(TIMEOUT_CYCLES - 1));

  // Wait-cycle counter, restarted whenever a new Wishbone cycle opens
  always_ff @(posedge sys_clk_i or negedge sys_res_n_i) begin
    if (!sys_res_n_i) begin
      tmo_cnt_reg <= 8'd0;
    end else if (start) begin
      tmo_cnt_reg <= 8'd0;
    end else if (wb_cyc_reg && !wb_ack_i) begin
      tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge sys_clk_i or negedge sys_res_n_i) begin
    if (!sys_res_n_i) begin
      bus_err_reg <= 1'b0;
    end else if (timeout_hit) begin
      bus_err_reg <= 1'b1;
    end
  end

  assign bus_err_o = bus_err_reg;
`else
  logic [31:0] unused_timeout_cycles;

  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign timeout_hit           = 1'b0;
  assign bus_err_o             = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge sys_clk_i or negedge sys_res_n_i) begin
    if (!sys_res_n_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: RUN lasts until every requested side has completed
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (cpu_stb_i) state_next = RUN;
      RUN: begin
        if ((ins_done_next | ~ins_req_reg) & (dat_done_next | ~dat_req_reg)) begin
          state_next = ACK;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the CPU request, capture ROM/Wishbone data and close the Wishbone cycle
  always_ff @(posedge sys_clk_i or negedge sys_res_n_i) begin
    if (!sys_res_n_i) begin
      ins_req_reg  <= 1'b0;
      dat_req_reg  <= 1'b0;
      ins_done_reg <= 1'b0;
      dat_done_reg <= 1'b0;
      rom_adr_reg  <= 13'd0;
      wb_adr_reg   <= 15'd0;
      wb_dat_reg   <= 16'd0;
      wb_we_reg    <= 1'b0;
      wb_cyc_reg   <= 1'b0;
      ins_dat_reg  <= 16'd0;
      dat_dat_reg  <= 16'd0;
    end else if (start) begin
      ins_req_reg  <= cpu_ins_cyc_i;
      dat_req_reg  <= cpu_dat_cyc_i;
      ins_done_reg <= 1'b0;
      dat_done_reg <= 1'b0;
      rom_adr_reg  <= cpu_ins_adr_i;
      wb_adr_reg   <= cpu_dat_adr_i;
      wb_dat_reg   <= cpu_dat_dat_i;
      wb_we_reg    <= cpu_dat_cyc_i & cpu_dat_we_i;
      wb_cyc_reg   <= cpu_dat_cyc_i;
    end else if (state_reg == RUN) begin
      ins_done_reg <= ins_done_next;
      dat_done_reg <= dat_done_next;
      if (!ins_done_reg) begin
        ins_dat_reg <= rom_dat_i;
      end
      if (wb_ack_seen) begin
        wb_cyc_reg <= 1'b0;
        wb_we_reg  <= 1'b0;
        if (!wb_we_reg) dat_dat_reg <= wb_dat_i;
      end else if (timeout_hit) begin
        wb_cyc_reg <= 1'b0;
        wb_we_reg  <= 1'b0;
        if (!wb_we_reg) dat_dat_reg <= 16'hFFFF;
      end
    end
  end

  assign cpu_ack_o     = (state_reg == ACK);
  assign cpu_ins_dat_o = ins_dat_reg;
  assign cpu_dat_dat_o = dat_dat_reg;
  assign rom_adr_o     = rom_adr_reg;
  assign wb_adr_o      = wb_adr_reg;
  assign wb_dat_o      = wb_dat_reg;
  assign wb_sel_o      = 2'b11;
  assign wb_we_o       = wb_we_reg;
  assign wb_cyc_o      = wb_cyc_reg;
  assign wb_stb_o      = wb_cyc_reg;

endmodule
